// File: rtl/qspi_bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// qspi_bus_arbiter_if
//
// Purpose: groups the two CPU requester ports (instruction fetch "i_*" and
// data load/store "d_*") and the QSPI engine control port ("eng_*") that meet
// at qspi_bus_arbiter.
//
// Modports:
//   slave  - the arbiter's view: requests and engine status in, grants,
//            responses and engine commands out.
//   master - the environment's view (CPU core + QSPI engine, or a bench).
//
// Handshake semantics (both requester ports):
//   A requester raises *_valid with *_addr (and d_we/d_wdata/d_wstrb) and
//   holds them stable until *_ready is seen high in the same cycle; that
//   cycle is the transfer. Dropping *_valid before *_ready withdraws the
//   request with no side effects. *_ready is only ever high together with
//   *_valid. Each accepted request receives exactly one *_rvalid pulse,
//   carrying *_rdata and *_err, some cycles later. There is no backpressure
//   on responses.
// -----------------------------------------------------------------------------
interface qspi_bus_arbiter_if;

  // Instruction-fetch port
  logic        i_valid;
  logic [25:0] i_addr;
  logic        i_ready;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        i_err;

  // Data load/store port
  logic        d_valid;
  logic [25:0] d_addr;
  logic        d_we;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic        d_ready;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        d_err;

  // QSPI transaction engine port
  logic        eng_start;
  logic [1:0]  eng_cs;
  logic [23:0] eng_addr;
  logic        eng_we;
  logic [31:0] eng_wdata;
  logic [3:0]  eng_wstrb;
  logic        eng_done;
  logic [31:0] eng_rdata;
  logic        eng_abort;

  modport slave (
    input  i_valid, i_addr,
    input  d_valid, d_addr, d_we, d_wdata, d_wstrb,
    input  eng_done, eng_rdata,
    output i_ready, i_rvalid, i_rdata, i_err,
    output d_ready, d_rvalid, d_rdata, d_err,
    output eng_start, eng_cs, eng_addr, eng_we, eng_wdata, eng_wstrb, eng_abort
  );

  modport master (
    output i_valid, i_addr,
    output d_valid, d_addr, d_we, d_wdata, d_wstrb,
    output eng_done, eng_rdata,
    input  i_ready, i_rvalid, i_rdata, i_err,
    input  d_ready, d_rvalid, d_rdata, d_err,
    input  eng_start, eng_cs, eng_addr, eng_we, eng_wdata, eng_wstrb, eng_abort
  );

endinterface

// File: rtl/qspi_bus_arbiter.sv
// -----------------------------------------------------------------------------
// qspi_bus_arbiter
//
// Purpose: shares one QSPI transaction engine between the CPU instruction
// fetch port and the data load/store port. Data requests have priority, but
// an ifetch that has been passed over FAIR_LIMIT times in a row wins the next
// arbitration. The winning request is latched, its chip select decoded from
// addr[25:24], and the engine is run through a start/done sequence guarded
// by a watchdog. The response (read data or error) goes back only to the
// requester that issued the transaction.
//
// Parameters:
//   FAIR_LIMIT  consecutive data grants allowed while an ifetch waits
//   TIMEOUT     cycles from eng_start to eng_abort when no eng_done arrives
//
// Ports:
//   clk          single clock
//   rst          synchronous active-high reset
//   bus          qspi_bus_arbiter_if.slave: requester ports and engine port
//   busy         high whenever the FSM is not IDLE
//   dbg_state_o  current FSM state (IDLE=0, ISSUE=1, WAIT=2, RESP=3)
// -----------------------------------------------------------------------------
module qspi_bus_arbiter #(
  parameter int FAIR_LIMIT = 4,
  parameter int TIMEOUT    = 1023
) (
  input  logic              clk,
  input  logic              rst,
  qspi_bus_arbiter_if.slave bus,
  output logic              busy,
  output logic [1:0]        dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [2:0] FAIR_MAX  = 3'(FAIR_LIMIT);
  // The watchdog is cleared in ISSUE and counts WAIT cycles from 0, so the
  // WAIT cycle holding TIMEOUT-1 is exactly TIMEOUT cycles after eng_start.
  localparam logic [9:0] WDOG_LAST = 10'(TIMEOUT - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t      state_q,   state_d;
  logic [2:0]  starve_q,  starve_d;
  logic [9:0]  wdog_q,    wdog_d;
  logic        owner_q,   owner_d;     // 1 = data port, 0 = ifetch port
  logic [25:0] addr_q,    addr_d;
  logic        we_q,      we_d;
  logic [31:0] wdata_q,   wdata_d;
  logic [3:0]  wstrb_q,   wstrb_d;
  logic        err_q,     err_d;
  logic [31:0] i_rdata_q, i_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;

  // ---------------------------------------------------------------------------
  // Combinational helpers and pulse outputs
  // ---------------------------------------------------------------------------
  logic        pick_data;
  logic        illegal;
  logic        resp_load;
  logic [31:0] resp_rdata;
  logic        i_ready;
  logic        d_ready;
  logic        i_rvalid;
  logic        d_rvalid;
  logic        eng_start;
  logic        eng_abort;

  // Data wins unless ifetch is also waiting and has already been passed over
  // FAIR_LIMIT times in a row.
  assign pick_data = bus.d_valid && (!bus.i_valid || (starve_q != FAIR_MAX));

  // Address space 11 is unmapped, and the flash on chip select 0 is read-only
  // through this path.
  assign illegal = (addr_q[25:24] == 2'b11) ||
                   (we_q && (addr_q[25:24] == 2'b00));

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    starve_d   = starve_q;
    wdog_d     = wdog_q;
    owner_d    = owner_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    err_d      = err_q;
    resp_load  = 1'b0;
    resp_rdata = '0;
    i_ready    = 1'b0;
    d_ready    = 1'b0;
    i_rvalid   = 1'b0;
    d_rvalid   = 1'b0;
    eng_start  = 1'b0;
    eng_abort  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.d_valid || bus.i_valid) begin
          state_d = S_ISSUE;
          if (pick_data) begin
            d_ready = 1'b1;
            owner_d = 1'b1;
            addr_d  = bus.d_addr;
            we_d    = bus.d_we;
            wdata_d = bus.d_wdata;
            wstrb_d = bus.d_wstrb;
            // Only a data grant that overtakes a waiting ifetch counts
            // towards starvation; an uncontested grant resets the run.
            if (!bus.i_valid) begin
              starve_d = '0;
            end else if (starve_q != FAIR_MAX) begin
              starve_d = starve_q + 3'd1;
            end
          end else begin
            // Instruction fetches are always reads; write fields are zeroed
            // so the engine never sees stale data-port values.
            i_ready  = 1'b1;
            owner_d  = 1'b0;
            addr_d   = bus.i_addr;
            we_d     = 1'b0;
            wdata_d  = '0;
            wstrb_d  = '0;
            starve_d = '0;
          end
        end
      end

      S_ISSUE: begin
        if (illegal) begin
          err_d     = 1'b1;
          resp_load = 1'b1;
          state_d   = S_RESP;
        end else begin
          eng_start = 1'b1;
          wdog_d    = '0;
          state_d   = S_WAIT;
        end
      end

      S_WAIT: begin
        // A completion in the final watchdog cycle still counts as success.
        if (bus.eng_done) begin
          err_d      = 1'b0;
          resp_load  = 1'b1;
          resp_rdata = we_q ? 32'h0 : bus.eng_rdata;
          state_d    = S_RESP;
        end else if (wdog_q == WDOG_LAST) begin
          eng_abort = 1'b1;
          err_d     = 1'b1;
          resp_load = 1'b1;
          state_d   = S_RESP;
        end else begin
          wdog_d = wdog_q + 10'd1;
        end
      end

      S_RESP: begin
        if (owner_q) begin
          d_rvalid = 1'b1;
        end else begin
          i_rvalid = 1'b1;
        end
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Read data registers are per port so each requester sees its own last
  // response held between pulses; error and write responses load zero.
  assign i_rdata_d = (resp_load && !owner_q) ? resp_rdata : i_rdata_q;
  assign d_rdata_d = (resp_load &&  owner_q) ? resp_rdata : d_rdata_q;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      starve_q  <= '0;
      wdog_q    <= '0;
      owner_q   <= 1'b0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      err_q     <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      wdog_q    <= wdog_d;
      owner_q   <= owner_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      err_q     <= err_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.i_ready   = i_ready;
  assign bus.d_ready   = d_ready;
  assign bus.i_rvalid  = i_rvalid;
  assign bus.d_rvalid  = d_rvalid;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  // err is qualified by the owner's rvalid so the idle port always reads 0.
  assign bus.i_err     = i_rvalid & err_q;
  assign bus.d_err     = d_rvalid & err_q;

  // Engine fields come straight from the latched request, so they are stable
  // from ISSUE until the next grant.
  assign bus.eng_start = eng_start;
  assign bus.eng_abort = eng_abort;
  assign bus.eng_cs    = addr_q[25:24];
  assign bus.eng_addr  = addr_q[23:0];
  assign bus.eng_we    = we_q;
  assign bus.eng_wdata = wdata_q;
  assign bus.eng_wstrb = wstrb_q;

  assign busy        = (state_q != S_IDLE);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_qspi_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_qspi_bus_arbiter
//
// Directed bench for qspi_bus_arbiter. The main initial block plays both
// requesters and the QSPI engine; a negedge monitor pops the expected-response
// queue on every *_rvalid. Inputs change on the falling edge, outputs are
// sampled on the falling edge (plus #1 for outputs that depend on inputs).
// -----------------------------------------------------------------------------
module tb_qspi_bus_arbiter;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst;
  logic busy;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  qspi_bus_arbiter_if bus_if ();

  qspi_bus_arbiter #(
    .FAIR_LIMIT (4),
    .TIMEOUT    (1023)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus_if),
    .busy        (busy),
    .dbg_state_o (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state: {port(1=data), err, rdata}
  // ---------------------------------------------------------------------------
  logic [33:0] exp_q[$];
  int test_cnt = 0;
  int fail_cnt = 0;
  int ready_cyc = 0;
  int start_cyc = 0;
  int done_cyc  = 0;
  int rv_cyc    = 0;
  int abort_cyc = 0;
  logic prev_rv = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    test_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Response monitor
  always @(negedge clk) begin
    logic        rv;
    logic [33:0] got;
    logic [33:0] expv;
    rv = bus_if.i_rvalid | bus_if.d_rvalid;
    if (!rst && rv) begin
      check("rvalid_exclusive", {63'd0, bus_if.i_rvalid & bus_if.d_rvalid}, 64'd0);
      check("rvalid_one_cycle", {63'd0, prev_rv}, 64'd0);
      got = bus_if.d_rvalid ? {1'b1, bus_if.d_err, bus_if.d_rdata}
                            : {1'b0, bus_if.i_err, bus_if.i_rdata};
      rv_cyc = cyc;
      check("resp_pending", {63'd0, exp_q.size() != 0}, 64'd1);
      if (exp_q.size() != 0) begin
        expv = exp_q.pop_front();
        check("resp_port_err_data", {30'd0, got}, {30'd0, expv});
      end
    end
    prev_rv = rst ? 1'b0 : rv;
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  // Presents one request and returns in the following (ISSUE) cycle, #1 after
  // the falling edge, with valid dropped.
  task automatic request(input bit is_data, input logic [25:0] addr, input logic we,
                         input logic [31:0] wdata, input logic [3:0] wstrb);
    int n;
    logic rdy;
    @(negedge clk);
    if (is_data) begin
      bus_if.d_valid = 1'b1;
      bus_if.d_addr  = addr;
      bus_if.d_we    = we;
      bus_if.d_wdata = wdata;
      bus_if.d_wstrb = wstrb;
    end else begin
      bus_if.i_valid = 1'b1;
      bus_if.i_addr  = addr;
    end
    #1;
    n = 0;
    rdy = is_data ? bus_if.d_ready : bus_if.i_ready;
    while (!rdy && n < 20) begin
      @(negedge clk);
      #1;
      n++;
      rdy = is_data ? bus_if.d_ready : bus_if.i_ready;
    end
    check(is_data ? "d_ready_grant" : "i_ready_grant", {63'd0, rdy}, 64'd1);
    ready_cyc = cyc;
    @(negedge clk);
    bus_if.i_valid = 1'b0;
    bus_if.d_valid = 1'b0;
    #1;
  endtask

  // Engine model: completes `delay` cycles after eng_start; returns on the
  // falling edge of the cycle after the done pulse.
  task automatic pulse_done(input int delay, input logic [31:0] data);
    repeat (delay) @(negedge clk);
    bus_if.eng_done  = 1'b1;
    bus_if.eng_rdata = data;
    done_cyc = cyc;
    @(negedge clk);
    bus_if.eng_done  = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    #2;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      #2;
      n++;
    end
    check(tag, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"}, {63'd0, busy}, 64'd0);
    check({tag, "_state"}, {62'd0, dbg_state}, 64'd0);
    check({tag, "_ctl"}, {50'd0, bus_if.i_ready, bus_if.d_ready, bus_if.i_rvalid,
          bus_if.d_rvalid, bus_if.i_err, bus_if.d_err, bus_if.eng_start,
          bus_if.eng_abort, bus_if.eng_we, bus_if.eng_cs, bus_if.eng_wstrb}, 64'd0);
    check({tag, "_rdata"}, {bus_if.i_rdata, bus_if.d_rdata}, 64'd0);
    check({tag, "_eng"}, {8'd0, bus_if.eng_addr, bus_if.eng_wdata}, 64'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    bit          exp_order [10];
    logic        who;
    logic [31:0] data;
    int          n;

    exp_order = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    rst = 1'b1;
    bus_if.i_valid   = 1'b0;
    bus_if.i_addr    = '0;
    bus_if.d_valid   = 1'b0;
    bus_if.d_addr    = '0;
    bus_if.d_we      = 1'b0;
    bus_if.d_wdata   = '0;
    bus_if.d_wstrb   = '0;
    bus_if.eng_done  = 1'b0;
    bus_if.eng_rdata = '0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check_quiet("reset");
    rst = 1'b0;

    // Single ifetch, flash, 20-cycle engine latency
    exp_q.push_back({1'b0, 1'b0, 32'hDEADBEEF});
    request(1'b0, 26'h0000100, 1'b0, 32'h0, 4'h0);
    start_cyc = cyc;
    check("t1_eng_start", {63'd0, bus_if.eng_start}, 64'd1);
    check("t1_eng_cs", {62'd0, bus_if.eng_cs}, 64'd0);
    check("t1_eng_addr", {40'd0, bus_if.eng_addr}, 64'h000100);
    check("t1_accept_to_start", 64'(start_cyc - ready_cyc), 64'd1);
    pulse_done(20, 32'hDEADBEEF);
    wait_drain("t1_resp");
    check("t1_resp_latency", 64'(rv_cyc - done_cyc), 64'd1);
    @(negedge clk);
    #1;
    check("t1_rvalid_drop", {63'd0, bus_if.i_rvalid}, 64'd0);
    check("t1_idle", {63'd0, busy}, 64'd0);

    // Data read from PSRAM1 (chip select 2)
    exp_q.push_back({1'b1, 1'b0, 32'h0BADF00D});
    request(1'b1, 26'h2000004, 1'b0, 32'h0, 4'h0);
    check("rd2_eng_cs", {62'd0, bus_if.eng_cs}, 64'd2);
    check("rd2_eng_we", {63'd0, bus_if.eng_we}, 64'd0);
    pulse_done(5, 32'h0BADF00D);
    wait_drain("rd2_resp");

    // Illegal read to the unmapped window: error, rdata cleared
    exp_q.push_back({1'b1, 1'b1, 32'h0});
    request(1'b1, 26'h3000000, 1'b0, 32'h0, 4'h0);
    check("ill_rd_no_start", {63'd0, bus_if.eng_start}, 64'd0);
    wait_drain("ill_rd_resp");
    check("ill_rd_latency", 64'(rv_cyc - ready_cyc), 64'd2);

    // Illegal write to flash
    exp_q.push_back({1'b1, 1'b1, 32'h0});
    request(1'b1, 26'h0001000, 1'b1, 32'hCAFEF00D, 4'hF);
    check("ill_wr_no_start", {63'd0, bus_if.eng_start}, 64'd0);
    wait_drain("ill_wr_resp");
    check("ill_wr_latency", 64'(rv_cyc - ready_cyc), 64'd2);

    // Legal write to PSRAM0; write response carries rdata 0
    exp_q.push_back({1'b1, 1'b0, 32'h0});
    request(1'b1, 26'h1000040, 1'b1, 32'h12345678, 4'hF);
    check("wr_eng_start", {63'd0, bus_if.eng_start}, 64'd1);
    check("wr_eng_cs", {62'd0, bus_if.eng_cs}, 64'd1);
    check("wr_eng_we", {63'd0, bus_if.eng_we}, 64'd1);
    check("wr_eng_fields", {4'd0, bus_if.eng_addr, bus_if.eng_wdata, bus_if.eng_wstrb},
          {4'd0, 24'h000040, 32'h12345678, 4'hF});
    repeat (2) @(negedge clk);
    #1;
    check("wr_fields_stable", {4'd0, bus_if.eng_addr, bus_if.eng_wdata, bus_if.eng_wstrb},
          {4'd0, 24'h000040, 32'h12345678, 4'hF});
    pulse_done(1, 32'hAAAA5555);
    wait_drain("wr_resp");
    check("wr_resp_latency", 64'(rv_cyc - done_cyc), 64'd1);

    // Fairness: both ports requesting continuously
    @(negedge clk);
    bus_if.i_valid = 1'b1;
    bus_if.i_addr  = 26'h0000200;
    bus_if.d_valid = 1'b1;
    bus_if.d_addr  = 26'h1000010;
    bus_if.d_we    = 1'b0;
    for (int g = 0; g < 10; g++) begin
      #1;
      n = 0;
      while (!(bus_if.i_ready || bus_if.d_ready) && n < 20) begin
        @(negedge clk);
        #1;
        n++;
      end
      check("fair_grant_seen", {63'd0, bus_if.i_ready | bus_if.d_ready}, 64'd1);
      who = bus_if.d_ready;
      check($sformatf("fair_order_%0d", g), {63'd0, who}, {63'd0, exp_order[g]});
      @(negedge clk);
      if (g == 9) begin
        bus_if.i_valid = 1'b0;
        bus_if.d_valid = 1'b0;
      end
      @(negedge clk);
      data = $urandom;
      exp_q.push_back({who, 1'b0, data});
      bus_if.eng_done  = 1'b1;
      bus_if.eng_rdata = data;
      @(negedge clk);
      bus_if.eng_done = 1'b0;
      @(negedge clk);
    end
    wait_drain("fair_drain");

    // Watchdog expiry on an ifetch
    exp_q.push_back({1'b0, 1'b1, 32'h0});
    request(1'b0, 26'h2000010, 1'b0, 32'h0, 4'h0);
    start_cyc = cyc;
    check("to_eng_start", {63'd0, bus_if.eng_start}, 64'd1);
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!bus_if.eng_abort && n < 1100);
    abort_cyc = cyc;
    check("to_abort_seen", {63'd0, bus_if.eng_abort}, 64'd1);
    check("to_abort_latency", 64'(abort_cyc - start_cyc), 64'd1023);
    @(negedge clk);
    #1;
    check("to_abort_pulse", {63'd0, bus_if.eng_abort}, 64'd0);
    wait_drain("to_resp");
    check("to_resp_after_abort", 64'(rv_cyc - abort_cyc), 64'd1);

    // Done in the very cycle the watchdog would fire
    exp_q.push_back({1'b1, 1'b0, 32'h55AA33CC});
    request(1'b1, 26'h1000080, 1'b0, 32'h0, 4'h0);
    repeat (1023) @(negedge clk);
    bus_if.eng_done  = 1'b1;
    bus_if.eng_rdata = 32'h55AA33CC;
    #1;
    check("edge_no_abort", {63'd0, bus_if.eng_abort}, 64'd0);
    @(negedge clk);
    bus_if.eng_done = 1'b0;
    wait_drain("edge_resp");

    // Reset in the middle of WAIT, then a fresh request
    request(1'b1, 26'h1000100, 1'b0, 32'h0, 4'h0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check_quiet("rst_wait");
    rst = 1'b0;
    exp_q.push_back({1'b0, 1'b0, 32'h600DCAFE});
    request(1'b0, 26'h0000300, 1'b0, 32'h0, 4'h0);
    check("post_rst_start", {63'd0, bus_if.eng_start}, 64'd1);
    pulse_done(2, 32'h600DCAFE);
    wait_drain("post_rst_resp");

    // eng_done outside WAIT is ignored
    @(negedge clk);
    bus_if.eng_done  = 1'b1;
    bus_if.eng_rdata = $urandom;
    @(negedge clk);
    bus_if.eng_done = 1'b0;
    #1;
    check("stray_done_idle", {63'd0, busy}, 64'd0);
    repeat (2) @(negedge clk);
    #2;
    check("final_drain", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

  // Global time bound
  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not finish, %0d tests run, %0d failed",
             test_cnt, fail_cnt);
    $fatal(1);
  end

endmodule
